// File: rtl/truth_table_capture.sv
// truth_table_capture: steps a function-under-test through every input row and captures its minterm mask, popcount and match flag
module truth_table_capture #(
  parameter int NVARS = 3,
  parameter int SETTLE = 1,
  localparam int ROWS = 2**NVARS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             f,
  input  logic [ROWS-1:0]  expected,
  output logic [NVARS-1:0] xyz,
  output logic             busy,
  output logic             done,
  output logic [ROWS-1:0]  mask,
  output logic [NVARS:0]   ones,
  output logic             match
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  state_t state_q, state_d;
  logic [NVARS-1:0] row_q, row_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ROWS-1:0] shadow_q, shadow_d, exp_q, exp_d, mask_q, mask_d, sampled;
  logic [NVARS:0] ones_q, ones_d, pop;
  logic busy_q, busy_d, done_q, done_d, match_q, match_d;
  logic last_tick, last_row;
  always_comb begin
    sampled = shadow_q;
    sampled[row_q] = f;
    pop = '0;
    for (int i = 0; i < ROWS; i++) pop = pop + {{NVARS{1'b0}}, sampled[i]};
    last_tick = cnt_q == 4'(SETTLE - 1);
    last_row = row_q == NVARS'(ROWS - 1);
    state_d = state_q;
    row_d = row_q;
    cnt_d = cnt_q;
    shadow_d = shadow_q;
    exp_d = exp_q;
    mask_d = mask_q;
    ones_d = ones_q;
    match_d = match_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_WAIT;
        row_d = '0;
        cnt_d = '0;
        shadow_d = '0;
        exp_d = expected;
        busy_d = 1'b1;
      end
      S_WAIT: begin
        cnt_d = last_tick ? '0 : cnt_q + 4'd1;
        shadow_d = last_tick ? sampled : shadow_q;
        if (last_tick && last_row) begin
          state_d = S_DONE;
          row_d = '0;
          mask_d = sampled;
          ones_d = pop;
          match_d = sampled == exp_q;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else if (last_tick) row_d = row_q + NVARS'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q <= '0;
      cnt_q <= '0;
      shadow_q <= '0;
      exp_q <= '0;
      mask_q <= '0;
      ones_q <= '0;
      match_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      cnt_q <= cnt_d;
      shadow_q <= shadow_d;
      exp_q <= exp_d;
      mask_q <= mask_d;
      ones_q <= ones_d;
      match_q <= match_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign xyz = row_q;
  assign busy = busy_q;
  assign done = done_q;
  assign mask = mask_q;
  assign ones = ones_q;
  assign match = match_q;
endmodule

// File: tb/tb_truth_table_capture.sv
// tb_truth_table_capture: randomized scoreboard bench for truth_table_capture at SETTLE=1 and SETTLE=3
module tb_truth_table_capture;
  localparam int ROWS = 8;
  typedef struct {
    logic [7:0] m;
    int n;
    bit mt;
    int k;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start [2];
  logic f [2];
  logic [7:0] expv [2];
  logic [7:0] tbl [2];
  logic [2:0] xyz [2];
  logic busy [2];
  logic done [2];
  logic [7:0] mask [2];
  logic [3:0] ones [2];
  logic match [2];
  int st [2];
  int next_ok [2];
  logic [7:0] last_mask [2];
  exp_t sbq [2][$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int j;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign f[0] = tbl[0][xyz[0]];
  assign f[1] = tbl[1][xyz[1]];
  truth_table_capture #(.NVARS(3), .SETTLE(1)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .f(f[0]), .expected(expv[0]),
    .xyz(xyz[0]), .busy(busy[0]), .done(done[0]), .mask(mask[0]), .ones(ones[0]), .match(match[0])
  );
  truth_table_capture #(.NVARS(3), .SETTLE(3)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .f(f[1]), .expected(expv[1]),
    .xyz(xyz[1]), .busy(busy[1]), .done(done[1]), .mask(mask[1]), .ones(ones[1]), .match(match[1])
  );
  task automatic chk(input string nm, input int i, input int act, input int ex);
    checks++;
    if (act != ex) begin
      errors++;
      $display("FAIL %s[u%0d]: got %0d expected %0d at t=%0t", nm, i, act, ex, $time);
    end
  endtask
  function automatic logic [7:0] table_of(input int id, input logic [7:0] rnd);
    logic [7:0] t;
    logic x, y, z;
    for (int r = 0; r < ROWS; r++) begin
      x = r[2];
      y = r[1];
      z = r[0];
      case (id)
        0: t[r] = ~x & y & ~z;
        1: t[r] = (x & y) | (x & z) | (y & z);
        2: t[r] = 1'b1;
        3: t[r] = 1'b0;
        4: t[r] = x ^ z;
        default: t[r] = rnd[r];
      endcase
    end
    return t;
  endfunction
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (sbq[i].size() > 0 && cyc >= sbq[i][0].k) begin
          j = cyc - sbq[i][0].k;
          if (j < ROWS * st[i]) begin
            chk("busy", i, int'(busy[i]), 1);
            chk("done_early", i, int'(done[i]), 0);
            chk("xyz", i, int'(xyz[i]), j / st[i]);
          end else begin
            chk("done", i, int'(done[i]), 1);
            chk("busy_at_done", i, int'(busy[i]), 0);
            chk("xyz_at_done", i, int'(xyz[i]), 0);
            chk("mask", i, int'(mask[i]), int'(sbq[i][0].m));
            chk("ones", i, int'(ones[i]), sbq[i][0].n);
            chk("match", i, int'(match[i]), int'(sbq[i][0].mt));
            last_mask[i] = sbq[i][0].m;
            void'(sbq[i].pop_front());
          end
        end else begin
          chk("idle_busy", i, int'(busy[i]), 0);
          chk("idle_done", i, int'(done[i]), 0);
          chk("idle_xyz", i, int'(xyz[i]), 0);
          chk("mask_hold", i, int'(mask[i]), int'(last_mask[i]));
        end
      end
    end
  end
  task automatic try_start(input int i, input int id, input logic [7:0] rnd, input logic [7:0] ex, output bit acc);
    exp_t e;
    acc = (cyc + 1) >= next_ok[i];
    if (acc) begin
      tbl[i] = table_of(id, rnd);
      expv[i] = ex;
      e.m = tbl[i];
      e.n = $countones(tbl[i]);
      e.mt = tbl[i] == ex;
      e.k = cyc + 1;
      sbq[i].push_back(e);
      next_ok[i] = e.k + ROWS * st[i] + 2;
    end
    start[i] = 1'b1;
    @(negedge clk);
    #1 start[i] = 1'b0;
  endtask
  task automatic start_cap(input int i, input int id, input logic [7:0] rnd, input logic [7:0] ex);
    bit acc = 1'b0;
    int t = 0;
    while (!acc && t < 60) begin
      try_start(i, id, rnd, ex, acc);
      t++;
    end
    if (!acc) chk("start_accept", i, 0, 1);
  endtask
  task automatic wait_idle(input int i);
    int t = 0;
    while (sbq[i].size() > 0 && t < 300) begin
      expv[i] = 8'($urandom);
      @(negedge clk);
      #1 t++;
    end
    if (sbq[i].size() > 0) chk("wait_timeout", i, sbq[i].size(), 0);
  endtask
  initial begin
    bit acc;
    int t;
    int i;
    int id;
    logic [7:0] rnd;
    logic [7:0] ex;
    st[0] = 1;
    st[1] = 3;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0;
      tbl[k] = '0;
      expv[k] = '0;
      next_ok[k] = 0;
      last_mask[k] = '0;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ones", k, int'(ones[k]), 0);
      chk("rst_match", k, int'(match[k]), 0);
      chk("rst_mask", k, int'(mask[k]), 0);
    end
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    start_cap(0, 0, 8'h00, 8'h04);
    wait_idle(0);
    start_cap(0, 1, 8'h00, 8'hE9);
    wait_idle(0);
    repeat (10) begin
      @(negedge clk);
      #1;
    end
    start_cap(0, 2, 8'h00, 8'hFF);
    wait_idle(0);
    start_cap(0, 3, 8'h00, 8'h00);
    wait_idle(0);
    start_cap(1, 4, 8'h00, 8'h5A);
    wait_idle(1);
    start_cap(0, 5, 8'($urandom), 8'($urandom));
    repeat (ROWS + 3) try_start(0, 5, 8'($urandom), 8'($urandom), acc);
    wait_idle(0);
    for (int n = 0; n < 20; n++) begin
      i = $urandom_range(0, 1);
      id = $urandom_range(0, 5);
      rnd = 8'($urandom);
      ex = $urandom_range(0, 1) ? table_of(id, rnd) : 8'($urandom);
      start_cap(i, id, rnd, ex);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        #1;
      end
    end
    wait_idle(0);
    wait_idle(1);
    start_cap(0, 2, 8'h00, 8'hFF);
    wait_idle(0);
    start_cap(0, 2, 8'h00, 8'hFF);
    t = 0;
    while (xyz[0] != 3'd5 && t < 20) begin
      @(negedge clk);
      #1 t++;
    end
    chk("reach_row5", 0, int'(xyz[0]), 5);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("arst_xyz", k, int'(xyz[k]), 0);
      chk("arst_busy", k, int'(busy[k]), 0);
      chk("arst_done", k, int'(done[k]), 0);
      chk("arst_mask", k, int'(mask[k]), 0);
      chk("arst_ones", k, int'(ones[k]), 0);
      chk("arst_match", k, int'(match[k]), 0);
      sbq[k].delete();
      next_ok[k] = 0;
      last_mask[k] = '0;
    end
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      #1;
    end
    start_cap(0, 4, 8'h00, 8'h5A);
    wait_idle(0);
    start_cap(1, 1, 8'h00, 8'hE8);
    wait_idle(1);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
